// File: rtl/board_ui_pkg.sv
// Shared types for the board UI controller.
// Holds the UI sequence states, the slave selector type and the read/write operation type.
package board_ui_pkg;

    // UI sequence, in the order the operator walks through it.
    typedef enum logic [3:0] {
        SLAVE_SEL = 4'd0,
        RW_SEL    = 4'd1,
        EXT_SEL   = 4'd2,
        EXT_WR0   = 4'd3,
        EXT_WR1   = 4'd4,
        START0    = 4'd5,
        START1    = 4'd6,
        COUNT0    = 4'd7,
        COUNT1    = 4'd8,
        CONFIG    = 4'd9,
        READY     = 4'd10,
        COMM      = 4'd11,
        DONE      = 4'd12
    } ui_state_t;

    typedef logic [1:0] slave_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } operation_t;

    // First state after EXT_SEL given the external-write enables.
    function automatic ui_state_t ext_entry_state(input logic [1:0] en);
        if (en[0])      return EXT_WR0;
        else if (en[1]) return EXT_WR1;
        else            return START0;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises and debounces one active-low push button.
// Ports: clk, rstN (async active-low), key_n (raw button, idle high),
//        press (1-cycle event per debounced press).
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rstN,
    input  logic key_n,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1, sync2, sync_q;
    logic             level;
    logic             armed;
    logic [CNT_W-1:0] cnt;

    // Sync chain, stability counter and accepted level.
    // armed stays low until a debounced release is seen, so a key held
    // through reset cannot produce an event.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            sync_q <= 1'b1;
            cnt    <= '0;
            level  <= 1'b1;
            armed  <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync1  <= key_n;
            sync2  <= sync1;
            sync_q <= sync2;
            press  <= 1'b0;
            if (sync2 != sync_q)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_MAX) begin
                level <= sync_q;
                if (sync_q)
                    armed <= 1'b1;
                if (!sync_q && level && armed)
                    press <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/board_ui_controller.sv
// Switch/key driven configuration sequencer for a two-master board setup.
// Ports: clk, rstN; jump_stateN/jump_next_addr keys; SW switches;
//        latched slave/rw/ext-enable selections; external write strobe+payload;
//        master start addresses and counts; config/com start handshakes;
//        read-back address strobe; ready/done LEDs; current state.
module board_ui_controller
    import board_ui_pkg::*;
#(
    parameter int unsigned DATA_WIDTH             = 16,
    parameter int unsigned MASTER_ADDR_WIDTH      = 12,
    parameter int unsigned MAX_MASTER_WRITE_DEPTH = 16,
    parameter int unsigned DEBOUNCE_CYCLES        = 4
) (
    input  logic                                      clk,
    input  logic                                      rstN,
    input  logic                                      jump_stateN,
    input  logic                                      jump_next_addr,
    input  logic [17:0]                               SW,
    output slave_t                                    m0_slave,
    output slave_t                                    m1_slave,
    output logic [1:0]                                m_rw,
    output logic [1:0]                                ext_write_en,
    output logic                                      ext_wr_valid,
    output logic                                      ext_wr_master,
    output logic [$clog2(MAX_MASTER_WRITE_DEPTH)-1:0] ext_wr_addr,
    output logic [DATA_WIDTH-1:0]                     ext_wr_data,
    output logic [MASTER_ADDR_WIDTH-1:0]              m0_start_addr,
    output logic [MASTER_ADDR_WIDTH-1:0]              m1_start_addr,
    output logic [MASTER_ADDR_WIDTH-1:0]              m0_addr_count,
    output logic [MASTER_ADDR_WIDTH-1:0]              m1_addr_count,
    output logic                                      config_start,
    input  logic                                      config_done,
    output logic                                      com_start,
    input  logic                                      com_done,
    output logic [MASTER_ADDR_WIDTH-1:0]              rd_addr,
    output logic                                      rd_valid,
    output logic                                      communication_ready,
    output logic                                      communication_done,
    output logic [3:0]                                state
);

    localparam int unsigned WR_AW = $clog2(MAX_MASTER_WRITE_DEPTH);
    localparam int unsigned AW    = MASTER_ADDR_WIDTH;
    localparam logic [WR_AW-1:0] WR_LAST = WR_AW'(MAX_MASTER_WRITE_DEPTH - 1);

    logic jump_ev, next_raw, next_ev;
    wire  unused_sw = &{1'b0, SW};

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_jump_db (
        .clk(clk), .rstN(rstN), .key_n(jump_stateN), .press(jump_ev)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
        .clk(clk), .rstN(rstN), .key_n(jump_next_addr), .press(next_raw)
    );

    // A simultaneous jump swallows the next-address event.
    assign next_ev = next_raw & ~jump_ev;

    ui_state_t              state_q, state_d;
    logic [WR_AW-1:0]       wr_addr_q, wr_addr_d;
    logic                   rd_pend_q, rd_pend_d;
    slave_t                 m0_slave_d, m1_slave_d;
    logic [1:0]             m_rw_d, ext_write_en_d;
    logic                   ext_wr_valid_d, ext_wr_master_d;
    logic [WR_AW-1:0]       ext_wr_addr_d;
    logic [DATA_WIDTH-1:0]  ext_wr_data_d;
    logic [AW-1:0]          m0_start_d, m1_start_d, m0_count_d, m1_count_d, rd_addr_d;
    logic                   config_start_d, com_start_d, rd_valid_d;
    logic                   comm_ready_d, comm_done_d;

    assign state = state_q;

    // State register and all latched outputs.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q             <= SLAVE_SEL;
            wr_addr_q           <= '0;
            rd_pend_q           <= 1'b0;
            m0_slave            <= '0;
            m1_slave            <= '0;
            m_rw                <= '0;
            ext_write_en        <= '0;
            ext_wr_valid        <= 1'b0;
            ext_wr_master       <= 1'b0;
            ext_wr_addr         <= '0;
            ext_wr_data         <= '0;
            m0_start_addr       <= '0;
            m1_start_addr       <= '0;
            m0_addr_count       <= '0;
            m1_addr_count       <= '0;
            config_start        <= 1'b0;
            com_start           <= 1'b0;
            rd_addr             <= '0;
            rd_valid            <= 1'b0;
            communication_ready <= 1'b0;
            communication_done  <= 1'b0;
        end else begin
            state_q             <= state_d;
            wr_addr_q           <= wr_addr_d;
            rd_pend_q           <= rd_pend_d;
            m0_slave            <= m0_slave_d;
            m1_slave            <= m1_slave_d;
            m_rw                <= m_rw_d;
            ext_write_en        <= ext_write_en_d;
            ext_wr_valid        <= ext_wr_valid_d;
            ext_wr_master       <= ext_wr_master_d;
            ext_wr_addr         <= ext_wr_addr_d;
            ext_wr_data         <= ext_wr_data_d;
            m0_start_addr       <= m0_start_d;
            m1_start_addr       <= m1_start_d;
            m0_addr_count       <= m0_count_d;
            m1_addr_count       <= m1_count_d;
            config_start        <= config_start_d;
            com_start           <= com_start_d;
            rd_addr             <= rd_addr_d;
            rd_valid            <= rd_valid_d;
            communication_ready <= comm_ready_d;
            communication_done  <= comm_done_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d         = state_q;
        wr_addr_d       = wr_addr_q;
        rd_pend_d       = 1'b0;
        m0_slave_d      = m0_slave;
        m1_slave_d      = m1_slave;
        m_rw_d          = m_rw;
        ext_write_en_d  = ext_write_en;
        ext_wr_valid_d  = 1'b0;
        ext_wr_master_d = ext_wr_master;
        ext_wr_addr_d   = ext_wr_addr;
        ext_wr_data_d   = ext_wr_data;
        m0_start_d      = m0_start_addr;
        m1_start_d      = m1_start_addr;
        m0_count_d      = m0_addr_count;
        m1_count_d      = m1_addr_count;
        config_start_d  = 1'b0;
        com_start_d     = 1'b0;
        rd_addr_d       = rd_addr;
        rd_valid_d      = rd_pend_q;

        case (state_q)
            SLAVE_SEL: if (jump_ev) begin
                m0_slave_d = SW[1:0];
                m1_slave_d = SW[3:2];
                state_d    = RW_SEL;
            end
            RW_SEL: if (jump_ev) begin
                m_rw_d  = SW[1:0];
                state_d = EXT_SEL;
            end
            EXT_SEL: if (jump_ev) begin
                ext_write_en_d = SW[1:0];
                wr_addr_d      = '0;
                state_d        = ext_entry_state(SW[1:0]);
            end
            EXT_WR0, EXT_WR1: begin
                // Both keys write; jump also closes the block.
                if (jump_ev || next_ev) begin
                    ext_wr_valid_d  = 1'b1;
                    ext_wr_master_d = (state_q == EXT_WR1);
                    ext_wr_addr_d   = wr_addr_q;
                    ext_wr_data_d   = SW[DATA_WIDTH-1:0];
                    wr_addr_d       = (wr_addr_q == WR_LAST) ? '0 : wr_addr_q + WR_AW'(1);
                end
                if (jump_ev) begin
                    wr_addr_d = '0;
                    state_d   = (state_q == EXT_WR0 && ext_write_en[1]) ? EXT_WR1 : START0;
                end
            end
            START0: if (jump_ev) begin
                m0_start_d = SW[AW-1:0];
                state_d    = START1;
            end
            START1: if (jump_ev) begin
                m1_start_d = SW[AW-1:0];
                state_d    = COUNT0;
            end
            COUNT0: if (jump_ev) begin
                m0_count_d = SW[AW-1:0];
                state_d    = COUNT1;
            end
            COUNT1: if (jump_ev) begin
                m1_count_d     = SW[AW-1:0];
                config_start_d = 1'b1;
                state_d        = CONFIG;
            end
            CONFIG: if (config_done) state_d = READY;
            READY: if (jump_ev) begin
                com_start_d = 1'b1;
                state_d     = COMM;
            end
            COMM: if (com_done) state_d = DONE;
            DONE: begin
                if (jump_ev) begin
                    state_d = SLAVE_SEL;
                end else if (next_ev) begin
                    rd_addr_d = SW[AW-1:0];
                    rd_pend_d = 1'b1;
                end
            end
            default: state_d = SLAVE_SEL;
        endcase

        comm_ready_d = (state_d == READY);
        comm_done_d  = (state_d == DONE);
    end

endmodule

// File: tb/tb_board_ui_controller.sv
module tb_board_ui_controller;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 12;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned WAW   = 4;

    localparam logic [3:0] S_SLAVE  = 4'd0;
    localparam logic [3:0] S_RW     = 4'd1;
    localparam logic [3:0] S_EXTSEL = 4'd2;
    localparam logic [3:0] S_WR0    = 4'd3;
    localparam logic [3:0] S_WR1    = 4'd4;
    localparam logic [3:0] S_START0 = 4'd5;
    localparam logic [3:0] S_CONFIG = 4'd9;
    localparam logic [3:0] S_READY  = 4'd10;
    localparam logic [3:0] S_COMM   = 4'd11;
    localparam logic [3:0] S_DONE   = 4'd12;

    logic           clk;
    logic           rstN;
    logic           jump_stateN, jump_next_addr;
    logic [17:0]    SW;
    logic [1:0]     m0_slave, m1_slave, m_rw, ext_write_en;
    logic           ext_wr_valid, ext_wr_master;
    logic [WAW-1:0] ext_wr_addr;
    logic [DW-1:0]  ext_wr_data;
    logic [AW-1:0]  m0_start_addr, m1_start_addr, m0_addr_count, m1_addr_count;
    logic           config_start, config_done, com_start, com_done;
    logic [AW-1:0]  rd_addr;
    logic           rd_valid, communication_ready, communication_done;
    logic [3:0]     state;

    board_ui_controller #(
        .DATA_WIDTH(DW), .MASTER_ADDR_WIDTH(AW),
        .MAX_MASTER_WRITE_DEPTH(DEPTH), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk), .rstN(rstN),
        .jump_stateN(jump_stateN), .jump_next_addr(jump_next_addr), .SW(SW),
        .m0_slave(m0_slave), .m1_slave(m1_slave), .m_rw(m_rw), .ext_write_en(ext_write_en),
        .ext_wr_valid(ext_wr_valid), .ext_wr_master(ext_wr_master),
        .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data),
        .m0_start_addr(m0_start_addr), .m1_start_addr(m1_start_addr),
        .m0_addr_count(m0_addr_count), .m1_addr_count(m1_addr_count),
        .config_start(config_start), .config_done(config_done),
        .com_start(com_start), .com_done(com_done),
        .rd_addr(rd_addr), .rd_valid(rd_valid),
        .communication_ready(communication_ready), .communication_done(communication_done),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic           m;
        logic [WAW-1:0] a;
        logic [DW-1:0]  d;
    } wr_t;

    wr_t got_q[$];
    int  cfg_cnt = 0;
    int  com_cnt = 0;
    int  rdv_cnt = 0;
    int  n_tests = 0;
    int  n_fail  = 0;

    // Observed write strobes and pulse-high cycles.
    always @(negedge clk) begin
        if (rstN) begin
            if (ext_wr_valid) got_q.push_back({ext_wr_master, ext_wr_addr, ext_wr_data});
            if (config_start) cfg_cnt++;
            if (com_start)    com_cnt++;
            if (rd_valid)     rdv_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({state, m0_slave, m1_slave, m_rw, ext_write_en, ext_wr_valid, ext_wr_master,
                     ext_wr_addr, ext_wr_data, m0_start_addr, m1_start_addr, m0_addr_count,
                     m1_addr_count, config_start, com_start, rd_addr, rd_valid,
                     communication_ready, communication_done});
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One press of 10 cycles on the chosen key(s), then a long release.
    task automatic press(input bit j, input bit nx);
        @(negedge clk);
        if (j)  jump_stateN    = 1'b0;
        if (nx) jump_next_addr = 1'b0;
        tick(10);
        jump_stateN    = 1'b1;
        jump_next_addr = 1'b1;
        tick(12);
    endtask

    // n writes into master m: n-1 next presses and a final jump press.
    task automatic do_writes(input bit m, input int n, input bit fixed);
        int          base;
        logic [17:0] s;
        wr_t         exp_l[$];
        base = got_q.size();
        for (int i = 0; i < n; i++) begin
            s = 18'($urandom);
            if (fixed) s[15:0] = 16'hA1 + 16'(i) * 16'h11;
            SW = s;
            exp_l.push_back({m, WAW'(i % DEPTH), s[DW-1:0]});
            press(i == n - 1, i != n - 1);
        end
        check($sformatf("wr_count_m%0d", m), 128'(got_q.size() - base), 128'(n));
        for (int i = 0; i < n; i++)
            if (base + i < got_q.size())
                check($sformatf("wr%0d_m%0d", i, m), 128'(got_q[base + i]), 128'(exp_l[i]));
    endtask

    // Full walk from SLAVE_SEL back to SLAVE_SEL.
    task automatic run_lap(input logic [3:0] slave_sw, input logic [1:0] en, input int n0,
                           input int n1, input bit fixed, input logic [AW-1:0] rd_sw);
        logic [17:0]   s;
        logic [AW-1:0] regs[4];
        logic [AW-1:0] obs;
        logic [3:0]    exp_st;
        int            c0, k0, r0;

        s = 18'($urandom);
        s[3:0] = slave_sw;
        SW = s;
        press(1, 0);
        check("slave_m0", 128'(m0_slave), 128'(slave_sw[1:0]));
        check("slave_m1", 128'(m1_slave), 128'(slave_sw[3:2]));
        check("st_rw", 128'(state), 128'(S_RW));

        s = 18'($urandom);
        SW = s;
        press(1, 0);
        check("m_rw", 128'(m_rw), 128'(s[1:0]));
        check("st_extsel", 128'(state), 128'(S_EXTSEL));

        s = 18'($urandom);
        s[1:0] = en;
        SW = s;
        press(1, 0);
        check("ext_en", 128'(ext_write_en), 128'(en));
        exp_st = en[0] ? S_WR0 : (en[1] ? S_WR1 : S_START0);
        check("st_after_extsel", 128'(state), 128'(exp_st));

        if (en[0]) begin
            do_writes(1'b0, n0, fixed);
            check("st_after_wr0", 128'(state), 128'(en[1] ? S_WR1 : S_START0));
        end
        if (en[1]) begin
            do_writes(1'b1, n1, 1'b0);
            check("st_after_wr1", 128'(state), 128'(S_START0));
        end

        c0 = cfg_cnt;
        for (int k = 0; k < 4; k++) begin
            s = 18'($urandom);
            SW = s;
            regs[k] = s[AW-1:0];
            press(1, 0);
            case (k)
                0:       obs = m0_start_addr;
                1:       obs = m1_start_addr;
                2:       obs = m0_addr_count;
                default: obs = m1_addr_count;
            endcase
            check($sformatf("addr_reg%0d", k), 128'(obs), 128'(regs[k]));
            check($sformatf("st_addr_reg%0d", k), 128'(state), 128'(S_START0 + 4'(k) + 4'd1));
        end
        check("cfg_start_pulse", 128'(cfg_cnt - c0), 128'(1));

        tick(5);
        check("st_config_wait", 128'(state), 128'(S_CONFIG));
        config_done = 1'b1;
        tick(1);
        config_done = 1'b0;
        tick(2);
        check("st_ready", 128'(state), 128'(S_READY));
        check("comm_ready", 128'(communication_ready), 128'(1));
        check("cfg_start_once", 128'(cfg_cnt - c0), 128'(1));

        k0 = com_cnt;
        press(1, 0);
        check("com_start_pulse", 128'(com_cnt - k0), 128'(1));
        check("st_comm", 128'(state), 128'(S_COMM));
        check("comm_ready_off", 128'(communication_ready), 128'(0));

        tick(3);
        com_done = 1'b1;
        tick(1);
        com_done = 1'b0;
        tick(2);
        check("st_done", 128'(state), 128'(S_DONE));
        check("comm_done", 128'(communication_done), 128'(1));

        r0 = rdv_cnt;
        s = 18'($urandom);
        s[AW-1:0] = rd_sw;
        SW = s;
        press(0, 1);
        check("rd_addr", 128'(rd_addr), 128'(rd_sw));
        check("rd_valid_pulse", 128'(rdv_cnt - r0), 128'(1));

        SW = 18'($urandom);
        press(1, 1);
        check("st_back", 128'(state), 128'(S_SLAVE));
        check("rd_valid_none", 128'(rdv_cnt - r0), 128'(1));
        check("rd_addr_kept", 128'(rd_addr), 128'(rd_sw));
        check("comm_done_off", 128'(communication_done), 128'(0));
        check("m0_slave_kept", 128'(m0_slave), 128'(slave_sw[1:0]));
        check("m1_count_kept", 128'(m1_addr_count), 128'(regs[3]));
    endtask

    initial begin
        logic [17:0] s;
        rstN           = 1'b0;
        jump_stateN    = 1'b1;
        jump_next_addr = 1'b1;
        SW             = '0;
        config_done    = 1'b0;
        com_done       = 1'b0;
        tick(3);
        check("reset_outs", all_outs(), 128'(0));
        rstN = 1'b1;
        tick(10);

        run_lap(4'b0101, 2'b01, 3, 0, 1'b1, 12'd4);
        run_lap(4'($urandom), 2'b11, 17, int'($urandom_range(1, 5)), 1'b0, AW'($urandom));
        run_lap(4'($urandom), 2'b10, 0, 2, 1'b0, AW'($urandom));

        // Reset in EXT_WR0 with the jump key already going down.
        SW = 18'($urandom);
        press(1, 0);
        SW = 18'($urandom);
        press(1, 0);
        s = 18'($urandom);
        s[1:0] = 2'b01;
        SW = s;
        press(1, 0);
        check("rst_st_wr0", 128'(state), 128'(S_WR0));
        SW = 18'($urandom);
        press(0, 1);
        @(negedge clk);
        jump_stateN = 1'b0;
        tick(3);
        rstN = 1'b0;
        #1;
        check("rst_async_outs", all_outs(), 128'(0));
        tick(3);
        rstN = 1'b1;
        tick(20);
        check("rst_held_no_event", 128'(state), 128'(S_SLAVE));
        jump_stateN = 1'b1;
        tick(15);
        check("rst_release_no_event", 128'(state), 128'(S_SLAVE));
        check("rst_m0_clear", 128'(m0_slave), 128'(0));
        s = 18'($urandom);
        SW = s;
        press(1, 0);
        check("rst_repress_state", 128'(state), 128'(S_RW));
        check("rst_repress_m1", 128'(m1_slave), 128'(s[3:2]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
